// File: rtl/mem_arbiter.sv
// Round-robin instruction/data arbiter onto a single RAM port with timeout abort and a sticky error flag.
// Optional MEMARB_STATS_EN adds icount/dcount/stallcount access and stall counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcount
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_e;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_e;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_e;

  state_e           state_q;
  grant_e           last_grant_q;
  logic [CNT_W-1:0] tmo_q;
  logic             memerr_q;

  logic d_req;
  logic acc_live;
  logic ram_ok;
  logic ram_err;
  logic tmo_hit;
  logic done;
  logic abort;

  assign d_req    = dREN | dWEN;
  // A granted requester that drops its strobe ends the access with no completion.
  assign acc_live = ((state_q == DACC) & d_req) | ((state_q == IACC) & iREN);
  assign ram_ok   = (ramstate == RAM_ACCESS);
  assign ram_err  = (ramstate == RAM_ERROR);
  assign tmo_hit  = (tmo_q >= CNT_W'(TIMEOUT_CYC - 1));
  assign done     = acc_live & (ram_ok | ram_err | tmo_hit);
  assign abort    = acc_live & ~ram_ok & (ram_err | tmo_hit);

  assign iwait  = iREN  & ~((state_q == IACC) & done);
  assign dwait  = d_req & ~((state_q == DACC) & done);
  assign memerr = memerr_q;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state_q)
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (done && !abort) dload = ramload;
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (done && !abort) iload = ramload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_INSTR;
      tmo_q        <= '0;
      memerr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req && (!iREN || last_grant_q == GNT_INSTR)) begin
            state_q      <= DACC;
            last_grant_q <= GNT_DATA;
            tmo_q        <= '0;
          end else if (iREN) begin
            state_q      <= IACC;
            last_grant_q <= GNT_INSTR;
            tmo_q        <= '0;
          end
        end
        default: begin
          if (!acc_live || done) state_q <= IDLE;
          else                   tmo_q   <= tmo_q + CNT_W'(1);
          if (abort) memerr_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEMARB_STATS_EN
  logic [31:0] icount_q;
  logic [31:0] dcount_q;
  logic [31:0] stall_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      if (state_q == IACC && done) icount_q <= icount_q + 32'd1;
      if (state_q == DACC && done) dcount_q <= dcount_q + 32'd1;
      if (iwait || dwait)          stall_q  <= stall_q + 32'd1;
    end
  end

  assign icount     = icount_q;
  assign dcount     = dcount_q;
  assign stallcount = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with a load scoreboard plus arbitration,
// withdrawal, reset-mid-access and (under MEMARB_STATS_EN) counter sequences.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        memerr;
`ifdef MEMARB_STATS_EN
  logic [31:0] icount;
  logic [31:0] dcount;
  logic [31:0] stallcount;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
`ifdef MEMARB_STATS_EN
    , .icount(icount), .dcount(dcount), .stallcount(stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        err_model = 1'b0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  // kind: 0 instr read, 1 data read, 2 data write, 3 data read+write
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned busy;
    logic [1:0]  fin;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drop_all();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload = '0;
  endtask

  task automatic do_reset();
    drop_all();
    nRST = 1'b0;
    err_model = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    logic        is_i;
    logic        abort;
    logic [1:0]  exp_strb;
    logic [31:0] exp_load;
    is_i     = (v.kind == 2'd0);
    abort    = (v.fin != ACCESS);
    exp_strb = (v.kind >= 2'd2) ? 2'b01 : 2'b10;
    @(posedge CLK); #1;
    iREN = is_i;
    dREN = (v.kind == 2'd1) || (v.kind == 2'd3);
    dWEN = (v.kind >= 2'd2);
    iaddr = v.addr; daddr = v.addr; dstore = v.wdata;
    ramstate = FREE; ramload = 32'h5A5A5A5A;
    @(negedge CLK);
    chk("idle_wait", 32'(is_i ? iwait : dwait), 32'd1);
    chk("idle_strobe", 32'({ramREN, ramWEN}), 32'd0);
    chk("idle_addr", ramaddr, 32'd0);
    exp_q.push_back(abort ? 32'd0 : v.rdata);
    for (int unsigned b = 0; b < v.busy; b++) begin
      @(posedge CLK); #1;
      ramstate = BUSY; ramload = $urandom;
      @(negedge CLK);
      chk("busy_wait", 32'(is_i ? iwait : dwait), 32'd1);
      chk("busy_load", is_i ? iload : dload, 32'd0);
      chk("busy_strobe", 32'({ramREN, ramWEN}), 32'(exp_strb));
      chk("busy_addr", ramaddr, v.addr);
    end
    @(posedge CLK); #1;
    ramstate = v.fin; ramload = v.rdata;
    @(negedge CLK);
    exp_load = exp_q.pop_front();
    chk("done_wait", 32'(is_i ? iwait : dwait), 32'd0);
    chk("done_load", is_i ? iload : dload, exp_load);
    chk("done_other_load", is_i ? dload : iload, 32'd0);
    chk("done_strobe", 32'({ramREN, ramWEN}), 32'(exp_strb));
    chk("done_addr", ramaddr, v.addr);
    if (!is_i) chk("done_store", ramstore, v.wdata);
    if (abort) err_model = 1'b1;
    @(posedge CLK); #1;
    drop_all();
    @(negedge CLK);
    chk("post_memerr", 32'(memerr), 32'(err_model));
    chk("post_strobe", 32'({ramREN, ramWEN}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic exp_d;
    vecs[0] = '{kind: 2'd0, addr: 32'h40,  wdata: 32'h0,    rdata: 32'h3C010001, busy: 0, fin: ACCESS};
    vecs[1] = '{kind: 2'd1, addr: 32'h100, wdata: 32'h0,    rdata: 32'h12345678, busy: 1, fin: ACCESS};
    vecs[2] = '{kind: 2'd2, addr: 32'h80,  wdata: 32'hDEAD, rdata: 32'h0BAD0BAD, busy: 2, fin: ACCESS};
    vecs[3] = '{kind: 2'd3, addr: 32'h84,  wdata: 32'h1111, rdata: 32'h00000005, busy: 0, fin: ACCESS};
    vecs[4] = '{kind: 2'd0, addr: 32'h44,  wdata: 32'h0,    rdata: 32'hCAFEF00D, busy: 1, fin: ACCESS};
    vecs[5] = '{kind: 2'd1, addr: 32'h200, wdata: 32'h0,    rdata: 32'h77777777, busy: 3, fin: BUSY};
    vecs[6] = '{kind: 2'd0, addr: 32'h48,  wdata: 32'h0,    rdata: 32'h00000077, busy: 0, fin: ACCESS};
    vecs[7] = '{kind: 2'd0, addr: 32'h4C,  wdata: 32'h0,    rdata: 32'h0000FFFF, busy: 1, fin: ERROR};
    vecs[8] = '{kind: 2'd2, addr: 32'h90,  wdata: 32'hBEEF, rdata: 32'h00000001, busy: 0, fin: ACCESS};

    do_reset();
    @(negedge CLK);
    chk("rst_memerr", 32'(memerr), 32'd0);
    chk("rst_strobe", 32'({ramREN, ramWEN}), 32'd0);
    chk("rst_wait", 32'({iwait, dwait}), 32'd0);
    chk("rst_loads", iload | dload, 32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Both requesters held continuously: grants alternate D, I, D, I with an IDLE cycle between.
    do_reset();
    @(posedge CLK); #1;
    iREN = 1'b1; dWEN = 1'b1; iaddr = 32'h400; daddr = 32'h800; dstore = 32'hA5;
    ramstate = ACCESS; ramload = 32'h99;
    exp_d = 1'b1;
    for (int unsigned cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLK);
      if (cyc % 2 == 0) begin
        chk("arb_idle_wait", 32'({iwait, dwait}), 32'd3);
        chk("arb_idle_strobe", 32'({ramREN, ramWEN}), 32'd0);
      end else if (exp_d) begin
        chk("arb_d_strobe", 32'({ramREN, ramWEN}), 32'd1);
        chk("arb_d_addr", ramaddr, 32'h800);
        chk("arb_d_wait", 32'({iwait, dwait}), 32'd2);
        chk("arb_d_load", dload, 32'h99);
        exp_d = 1'b0;
      end else begin
        chk("arb_i_strobe", 32'({ramREN, ramWEN}), 32'd2);
        chk("arb_i_addr", ramaddr, 32'h400);
        chk("arb_i_wait", 32'({iwait, dwait}), 32'd1);
        chk("arb_i_load", iload, 32'h99);
        exp_d = 1'b1;
      end
    end
    @(posedge CLK); #1 drop_all();
    @(posedge CLK); #1;

    // Instruction request withdrawn mid-access.
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    @(negedge CLK);
    chk("wd_idle_strobe", 32'(ramREN), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("wd_acc_strobe", 32'(ramREN), 32'd1);
    @(posedge CLK); #1 iREN = 1'b0;
    @(negedge CLK);
    chk("wd_drop_strobe", 32'(ramREN), 32'd0);
    chk("wd_drop_wait", 32'(iwait), 32'd0);
    chk("wd_drop_load", iload, 32'd0);
    @(posedge CLK); #1 iREN = 1'b1; ramstate = ACCESS; ramload = 32'h1234;
    @(negedge CLK);
    chk("wd_back_idle_wait", 32'(iwait), 32'd1);
    chk("wd_back_idle_strobe", 32'(ramREN), 32'd0);
    chk("wd_memerr", 32'(memerr), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("wd_retry_wait", 32'(iwait), 32'd0);
    chk("wd_retry_load", iload, 32'h1234);
    @(posedge CLK); #1 drop_all();

    // Reset pulsed mid-DACC: write strobe must drop asynchronously.
    @(posedge CLK); #1 dWEN = 1'b1; daddr = 32'h600; dstore = 32'h77; ramstate = BUSY;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_mid_wen", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_async_wen", 32'(ramWEN), 32'd0);
    chk("rst_mid_async_wait", 32'(dwait), 32'd1);
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_idle_wen", 32'(ramWEN), 32'd0);
    chk("rst_mid_idle_wait", 32'(dwait), 32'd1);
    @(posedge CLK); #1 drop_all();
    repeat (2) @(posedge CLK);

`ifdef MEMARB_STATS_EN
    // 3 instruction + 2 data accesses with one BUSY cycle: two wait-high cycles each.
    do_reset();
    @(negedge CLK);
    chk("stats_rst_i", icount, 32'd0);
    chk("stats_rst_d", dcount, 32'd0);
    chk("stats_rst_s", stallcount, 32'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      vec_t sv;
      sv = '{kind: (k < 3) ? 2'd0 : 2'd1, addr: 32'h1000 + 32'(k * 4), wdata: 32'h0,
             rdata: 32'hABC00000 + 32'(k), busy: 1, fin: ACCESS};
      run_txn(sv);
    end
    chk("stats_icount", icount, 32'd3);
    chk("stats_dcount", dcount, 32'd2);
    chk("stats_stall", stallcount, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
